// File: rtl/conv_layer_sequencer.sv
// Per-layer scheduler for the conv engine: loads biases and weights from the
// shared load stream, then runs the engine once per 8-filter output group.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | waiting for layer_start; cfg checked and latched on accept
// BIAS_RST  | one-cycle bias store address reset
// BIAS_LOAD | streaming bias beats into the bias store
// WT_RST    | one-cycle weight store address reset
// WT_LOAD   | streaming weight beats (one group, or all groups if resident)
// GO        | waiting for engine idle, then issue conv_go
// RUN       | engine running the current group, waiting for conv_done
// DONE      | one-cycle layer_done pulse
module conv_layer_sequencer #(
  parameter int WT_DEPTH        = 4096,
  parameter int WT_ADDR_WIDTH   = $clog2(WT_DEPTH),
  parameter int BIAS_GROUP_BITS = 7
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       layer_start,
  input  logic                       layer_abort,
  input  logic [BIAS_GROUP_BITS:0]   cfg_num_groups,
  input  logic [BIAS_GROUP_BITS:0]   cfg_bias_words,
  input  logic [WT_ADDR_WIDTH:0]     cfg_wt_words_per_group,
  input  logic                       cfg_wt_resident,
  input  logic [127:0]               ld_data,
  input  logic                       ld_valid,
  output logic                       ld_ready,
  output logic                       bias_wr_en,
  output logic [127:0]               bias_wr_data,
  output logic                       bias_wr_addr_rst,
  output logic                       wt_wr_en,
  output logic [71:0]                wt_wr_data,
  output logic                       wt_wr_addr_rst,
  output logic [BIAS_GROUP_BITS-1:0] conv_output_group,
  output logic [WT_ADDR_WIDTH-1:0]   conv_wt_base_addr,
  output logic                       conv_go,
  input  logic                       conv_busy,
  input  logic                       conv_done,
  output logic                       grp_active,
  output logic                       layer_busy,
  output logic                       layer_done,
  output logic                       layer_err
);

  localparam int CW = (WT_ADDR_WIDTH > BIAS_GROUP_BITS) ? WT_ADDR_WIDTH + 1 : BIAS_GROUP_BITS + 1;
  localparam int PW = WT_ADDR_WIDTH + BIAS_GROUP_BITS + 2;
  localparam logic [PW-1:0] DEPTH_P = PW'(WT_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_BIAS_RST, S_BIAS_LOAD, S_WT_RST, S_WT_LOAD, S_GO, S_RUN, S_DONE
  } state_t;

  state_t                     state_q, state_d;
  logic [BIAS_GROUP_BITS:0]   num_q, num_d;
  logic [BIAS_GROUP_BITS:0]   bias_words_q, bias_words_d;
  logic [WT_ADDR_WIDTH:0]     per_q, per_d;
  logic [CW-1:0]              wt_target_q, wt_target_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic                       resident_q, resident_d;
  logic [BIAS_GROUP_BITS-1:0] grp_q, grp_d;
  logic [WT_ADDR_WIDTH-1:0]   base_q, base_d;
  logic                       bias_rst_q, bias_rst_d;
  logic                       wt_rst_q, wt_rst_d;
  logic                       go_q, go_d;
  logic                       active_q, active_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic                       err_q, err_d;

  logic [PW-1:0] prod;
  logic [CW-1:0] cnt_inc;
  logic          reject, in_load, fire, last_grp;

  // 21-bit product so an oversized resident layer can never wrap into range.
  assign prod     = PW'(cfg_num_groups) * PW'(cfg_wt_words_per_group);
  assign reject   = (cfg_num_groups == '0) || (cfg_wt_resident && (prod > DEPTH_P));
  assign in_load  = (state_q == S_BIAS_LOAD) || (state_q == S_WT_LOAD);
  assign fire     = ld_valid && in_load;
  assign cnt_inc  = cnt_q + CW'(1);
  assign last_grp = ({1'b0, grp_q} == (num_q - (BIAS_GROUP_BITS+1)'(1)));

  assign ld_ready          = in_load;
  assign bias_wr_en        = fire && (state_q == S_BIAS_LOAD);
  assign wt_wr_en          = fire && (state_q == S_WT_LOAD);
  assign bias_wr_data      = ld_data;
  assign wt_wr_data        = ld_data[71:0];
  assign bias_wr_addr_rst  = bias_rst_q;
  assign wt_wr_addr_rst    = wt_rst_q;
  assign conv_output_group = grp_q;
  assign conv_wt_base_addr = base_q;
  assign conv_go           = go_q;
  assign grp_active        = active_q;
  assign layer_busy        = busy_q;
  assign layer_done        = done_q;
  assign layer_err         = err_q;

  always_comb begin
    state_d      = state_q;
    num_d        = num_q;
    bias_words_d = bias_words_q;
    per_d        = per_q;
    wt_target_d  = wt_target_q;
    resident_d   = resident_q;
    grp_d        = grp_q;
    base_d       = base_q;
    cnt_d        = cnt_q;
    err_d        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (layer_start) begin
          if (reject) begin
            err_d = 1'b1;
          end else begin
            num_d        = cfg_num_groups;
            bias_words_d = cfg_bias_words;
            per_d        = cfg_wt_words_per_group;
            resident_d   = cfg_wt_resident;
            wt_target_d  = cfg_wt_resident ? CW'(prod) : CW'(cfg_wt_words_per_group);
            grp_d        = '0;
            base_d       = '0;
            state_d      = S_BIAS_RST;
          end
        end
      end
      S_BIAS_RST: begin
        cnt_d   = '0;
        state_d = (bias_words_q == '0) ? S_WT_RST : S_BIAS_LOAD;
      end
      S_BIAS_LOAD: begin
        if (fire) begin
          cnt_d = cnt_inc;
          if (cnt_inc == CW'(bias_words_q)) state_d = S_WT_RST;
        end
      end
      S_WT_RST: begin
        cnt_d   = '0;
        state_d = (wt_target_q == '0) ? S_GO : S_WT_LOAD;
      end
      S_WT_LOAD: begin
        if (fire) begin
          cnt_d = cnt_inc;
          if (cnt_inc == wt_target_q) state_d = S_GO;
        end
      end
      S_GO: begin
        if (!conv_busy) state_d = S_RUN;
      end
      S_RUN: begin
        if (conv_done) begin
          if (last_grp) begin
            state_d = S_DONE;
          end else begin
            grp_d = grp_q + BIAS_GROUP_BITS'(1);
            if (resident_q) begin
              base_d  = base_q + per_q[WT_ADDR_WIDTH-1:0];
              state_d = S_GO;
            end else begin
              state_d = S_WT_RST;
            end
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort wins over everything, including a coincident conv_done.
    if (layer_abort) begin
      state_d = S_IDLE;
      grp_d   = grp_q;
      base_d  = base_q;
      err_d   = 1'b0;
    end

    bias_rst_d = (state_d == S_BIAS_RST);
    wt_rst_d   = (state_d == S_WT_RST);
    go_d       = (state_q == S_GO) && (state_d == S_RUN);
    active_d   = (state_d == S_RUN);
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      num_q        <= '0;
      bias_words_q <= '0;
      per_q        <= '0;
      wt_target_q  <= '0;
      resident_q   <= 1'b0;
      grp_q        <= '0;
      base_q       <= '0;
      cnt_q        <= '0;
      bias_rst_q   <= 1'b0;
      wt_rst_q     <= 1'b0;
      go_q         <= 1'b0;
      active_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      num_q        <= num_d;
      bias_words_q <= bias_words_d;
      per_q        <= per_d;
      wt_target_q  <= wt_target_d;
      resident_q   <= resident_d;
      grp_q        <= grp_d;
      base_q       <= base_d;
      cnt_q        <= cnt_d;
      bias_rst_q   <= bias_rst_d;
      wt_rst_q     <= wt_rst_d;
      go_q         <= go_d;
      active_q     <= active_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Directed bench for conv_layer_sequencer: a small engine model answers
// conv_go with conv_done, and a negedge monitor tallies every handshake.
module tb_conv_layer_sequencer;

  logic         clk = 1'b0;
  logic         rst;
  logic         layer_start, layer_abort;
  logic [7:0]   cfg_num_groups, cfg_bias_words;
  logic [12:0]  cfg_wt_words_per_group;
  logic         cfg_wt_resident;
  logic [127:0] ld_data;
  logic         ld_valid, ld_ready;
  logic         bias_wr_en, bias_wr_addr_rst, wt_wr_en, wt_wr_addr_rst;
  logic [127:0] bias_wr_data;
  logic [71:0]  wt_wr_data;
  logic [6:0]   conv_output_group;
  logic [11:0]  conv_wt_base_addr;
  logic         conv_go, conv_busy, conv_done;
  logic         grp_active, layer_busy, layer_done, layer_err;

  always #5 clk = ~clk;

  conv_layer_sequencer dut (
    .clk(clk), .rst(rst), .layer_start(layer_start), .layer_abort(layer_abort),
    .cfg_num_groups(cfg_num_groups), .cfg_bias_words(cfg_bias_words),
    .cfg_wt_words_per_group(cfg_wt_words_per_group), .cfg_wt_resident(cfg_wt_resident),
    .ld_data(ld_data), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .bias_wr_en(bias_wr_en), .bias_wr_data(bias_wr_data), .bias_wr_addr_rst(bias_wr_addr_rst),
    .wt_wr_en(wt_wr_en), .wt_wr_data(wt_wr_data), .wt_wr_addr_rst(wt_wr_addr_rst),
    .conv_output_group(conv_output_group), .conv_wt_base_addr(conv_wt_base_addr),
    .conv_go(conv_go), .conv_busy(conv_busy), .conv_done(conv_done),
    .grp_active(grp_active), .layer_busy(layer_busy), .layer_done(layer_done),
    .layer_err(layer_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Monitor tallies (monotonic; tests work on deltas from a snapshot)
  int bias_cnt = 0, wt_cnt = 0, brst_cnt = 0, wrst_cnt = 0, go_cnt = 0;
  int done_cnt = 0, err_cnt = 0, nv_err = 0, data_err = 0, rdy_err = 0, go_wide = 0;
  logic prev_go = 1'b0;
  int go_grp [32];
  int go_base[32];
  int go_wt  [32];
  int go_wrst[32];

  initial begin
    forever begin
      @(negedge clk);
      if (bias_wr_en) bias_cnt++;
      if (wt_wr_en) wt_cnt++;
      if (bias_wr_en && bias_wr_data !== ld_data) data_err++;
      if (wt_wr_en && wt_wr_data !== ld_data[71:0]) data_err++;
      if ((bias_wr_en || wt_wr_en) && !ld_valid) nv_err++;
      if (ld_ready && (grp_active || !layer_busy)) rdy_err++;
      if (bias_wr_addr_rst) brst_cnt++;
      if (wt_wr_addr_rst) wrst_cnt++;
      if (layer_done) done_cnt++;
      if (layer_err) err_cnt++;
      if (conv_go && prev_go) go_wide++;
      prev_go = conv_go;
      if (conv_go) begin
        if (go_cnt < 32) begin
          go_grp[go_cnt]  = int'(conv_output_group);
          go_base[go_cnt] = int'(conv_wt_base_addr);
          go_wt[go_cnt]   = wt_cnt;
          go_wrst[go_cnt] = wrst_cnt;
        end
        go_cnt++;
      end
    end
  end

  // Load stream driver
  bit rand_valid = 1'b0;
  initial begin
    ld_data  = '0;
    ld_valid = 1'b1;
    forever begin
      @(posedge clk); #1;
      ld_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
      ld_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Engine model: conv_done 4 cycles after conv_go; optional abort on the
  // second group's done, with a snapshot of the cycle after.
  bit   abort_en = 1'b0;
  int   abort_base = 0;
  int   ab_cnt = 0;
  logic ab_busy, ab_act, ab_done, ab_rst;
  initial begin
    bit do_ab;
    conv_done   = 1'b0;
    layer_abort = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (conv_go) begin
        do_ab = abort_en && (go_cnt - abort_base == 1);
        repeat (3) @(posedge clk);
        #1;
        conv_done   = 1'b1;
        layer_abort = do_ab;
        @(posedge clk); #1;
        conv_done   = 1'b0;
        layer_abort = 1'b0;
        if (do_ab) begin
          @(negedge clk);
          ab_busy = layer_busy;
          ab_act  = grp_active;
          ab_done = layer_done;
          ab_rst  = wt_wr_addr_rst;
          ab_cnt++;
        end
      end
    end
  end

  int s_bias, s_wt, s_brst, s_wrst, s_go, s_done, s_err;

  task automatic snap();
    s_bias = bias_cnt; s_wt = wt_cnt; s_brst = brst_cnt; s_wrst = wrst_cnt;
    s_go = go_cnt; s_done = done_cnt; s_err = err_cnt;
  endtask

  // Config is scrambled right after the start edge; the DUT must have latched it.
  task automatic start_layer(input int num, input int bias, input int per, input bit res);
    @(posedge clk); #1;
    cfg_num_groups         = 8'(num);
    cfg_bias_words         = 8'(bias);
    cfg_wt_words_per_group = 13'(per);
    cfg_wt_resident        = res;
    layer_start            = 1'b1;
    @(posedge clk); #1;
    layer_start            = 1'b0;
    cfg_num_groups         = 8'd1;
    cfg_bias_words         = 8'd0;
    cfg_wt_words_per_group = 13'd0;
    cfg_wt_resident        = ~res;
  endtask

  task automatic wait_done(input string tag, input int max);
    bit ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (done_cnt != s_done) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq(tag, 32'(ok), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; layer_start = 1'b0; conv_busy = 1'b0;
    cfg_num_groups = '0; cfg_bias_words = '0; cfg_wt_words_per_group = '0; cfg_wt_resident = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_flags", 32'({ld_ready, bias_wr_en, bias_wr_addr_rst, wt_wr_en, wt_wr_addr_rst,
                               conv_go, grp_active, layer_busy, layer_done, layer_err}), 32'd0);
    check_eq("rst_group", 32'(conv_output_group), 32'd0);
    check_eq("rst_base", 32'(conv_wt_base_addr), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Streamed: 3 groups, 2 bias beats, 5 weight beats per group
    snap();
    start_layer(3, 2, 5, 1'b0);
    wait_done("s_done_seen", 300);
    repeat (3) @(negedge clk);
    check_eq("s_bias_wr", 32'(bias_cnt - s_bias), 32'd2);
    check_eq("s_bias_rst", 32'(brst_cnt - s_brst), 32'd1);
    check_eq("s_wt_rst", 32'(wrst_cnt - s_wrst), 32'd3);
    check_eq("s_wt_wr", 32'(wt_cnt - s_wt), 32'd15);
    check_eq("s_go", 32'(go_cnt - s_go), 32'd3);
    check_eq("s_done_cnt", 32'(done_cnt - s_done), 32'd1);
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("s_grp%0d", i), 32'(go_grp[s_go+i]), 32'(i));
      check_eq($sformatf("s_base%0d", i), 32'(go_base[s_go+i]), 32'd0);
      check_eq($sformatf("s_wt_at_go%0d", i), 32'(go_wt[s_go+i] - s_wt), 32'(5*(i+1)));
      check_eq($sformatf("s_rst_at_go%0d", i), 32'(go_wrst[s_go+i] - s_wrst), 32'(i+1));
    end

    // Resident: 4 groups x 9 weight beats loaded once
    snap();
    start_layer(4, 1, 9, 1'b1);
    wait_done("r_done_seen", 300);
    check_eq("r_bias_wr", 32'(bias_cnt - s_bias), 32'd1);
    check_eq("r_wt_rst", 32'(wrst_cnt - s_wrst), 32'd1);
    check_eq("r_wt_wr", 32'(wt_cnt - s_wt), 32'd36);
    check_eq("r_go", 32'(go_cnt - s_go), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("r_grp%0d", i), 32'(go_grp[s_go+i]), 32'(i));
      check_eq($sformatf("r_base%0d", i), 32'(go_base[s_go+i]), 32'(9*i));
      check_eq($sformatf("r_wt_at_go%0d", i), 32'(go_wt[s_go+i] - s_wt), 32'd36);
      check_eq($sformatf("r_rst_at_go%0d", i), 32'(go_wrst[s_go+i] - s_wrst), 32'd1);
    end

    // Random ld_valid throttling
    rand_valid = 1'b1;
    snap();
    start_layer(1, 3, 3, 1'b0);
    wait_done("v_done_seen", 300);
    rand_valid = 1'b0;
    check_eq("v_bias_wr", 32'(bias_cnt - s_bias), 32'd3);
    check_eq("v_wt_wr", 32'(wt_cnt - s_wt), 32'd3);
    check_eq("v_wr_without_valid", 32'(nv_err), 32'd0);

    // Engine busy holds off conv_go
    conv_busy = 1'b1;
    snap();
    start_layer(1, 1, 1, 1'b0);
    repeat (10) @(negedge clk);
    check_eq("b_go_held", 32'(go_cnt - s_go), 32'd0);
    check_eq("b_layer_busy", 32'(layer_busy), 32'd1);
    @(posedge clk); #1;
    conv_busy = 1'b0;
    @(negedge clk);
    check_eq("b_go_before_edge", 32'(conv_go), 32'd0);
    @(negedge clk);
    check_eq("b_go_high", 32'(conv_go), 32'd1);
    @(negedge clk);
    check_eq("b_go_low", 32'(conv_go), 32'd0);
    wait_done("b_done_seen", 50);
    check_eq("b_go_count", 32'(go_cnt - s_go), 32'd1);

    // Rejected starts
    snap();
    start_layer(0, 1, 1, 1'b0);
    @(negedge clk);
    check_eq("e0_err", 32'(layer_err), 32'd1);
    check_eq("e0_busy", 32'(layer_busy), 32'd0);
    @(negedge clk);
    check_eq("e0_err_pulse", 32'(layer_err), 32'd0);

    snap();
    start_layer(200, 2, 32, 1'b1);
    @(negedge clk);
    check_eq("e1_err", 32'(layer_err), 32'd1);
    repeat (10) @(negedge clk);
    check_eq("e1_busy", 32'(layer_busy), 32'd0);
    check_eq("e1_writes", 32'((bias_cnt - s_bias) + (wt_cnt - s_wt)), 32'd0);
    check_eq("e1_err_cnt", 32'(err_cnt - s_err), 32'd1);

    snap();
    start_layer(2, 0, 2049, 1'b1);
    @(negedge clk);
    check_eq("e2_err_4098", 32'(layer_err), 32'd1);

    // Exactly WT_DEPTH resident beats is accepted
    snap();
    start_layer(2, 0, 2048, 1'b1);
    @(negedge clk);
    check_eq("f_no_err", 32'(layer_err), 32'd0);
    check_eq("f_busy", 32'(layer_busy), 32'd1);
    wait_done("f_done_seen", 4400);
    check_eq("f_bias_wr", 32'(bias_cnt - s_bias), 32'd0);
    check_eq("f_wt_wr", 32'(wt_cnt - s_wt), 32'd4096);
    check_eq("f_base1", 32'(go_base[s_go+1]), 32'd2048);

    // Abort coincident with the second group's conv_done
    abort_base = go_cnt;
    s_done = ab_cnt;
    abort_en = 1'b1;
    snap();
    start_layer(3, 1, 2, 1'b0);
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 200; i++) begin
        @(negedge clk);
        if (ab_cnt != 0) begin
          seen = 1'b1;
          break;
        end
      end
      check_eq("a_abort_seen", 32'(seen), 32'd1);
    end
    abort_en = 1'b0;
    check_eq("a_busy", 32'(ab_busy), 32'd0);
    check_eq("a_grp_active", 32'(ab_act), 32'd0);
    check_eq("a_done", 32'(ab_done), 32'd0);
    check_eq("a_wt_rst", 32'(ab_rst), 32'd0);
    repeat (5) @(negedge clk);
    check_eq("a_done_cnt", 32'(done_cnt - s_done), 32'd0);
    check_eq("a_go", 32'(go_cnt - s_go), 32'd2);
    check_eq("a_idle", 32'(layer_busy), 32'd0);

    snap();
    start_layer(2, 1, 1, 1'b0);
    wait_done("a2_done_seen", 200);
    check_eq("a2_go", 32'(go_cnt - s_go), 32'd2);
    check_eq("a2_grp0", 32'(go_grp[s_go]), 32'd0);
    check_eq("a2_grp1", 32'(go_grp[s_go+1]), 32'd1);

    check_eq("g_wr_without_valid", 32'(nv_err), 32'd0);
    check_eq("g_wr_data", 32'(data_err), 32'd0);
    check_eq("g_ready_outside_load", 32'(rdy_err), 32'd0);
    check_eq("g_go_width", 32'(go_wide), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_layer_sequencer.md
Name: conv_layer_sequencer

Overview:
Per-layer scheduler in front of the conv engine. For one layer it loads biases and weights into the engine's stores from a shared load stream, then runs the engine once per 8-filter output group. For each group it drives the output group index and weight base address, pulses go, and waits for done. Weights are either reloaded per group (streamed mode) or loaded once for the whole layer (resident mode).

Parameters:
WT_DEPTH, 4096, weight store depth in 72-bit words
WT_ADDR_WIDTH, $clog2(WT_DEPTH), weight address width
BIAS_GROUP_BITS, 7, output group index width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
layer_start  in  1  start pulse; sampled only in IDLE
layer_abort  in  1  return to IDLE next cycle from any state
cfg_num_groups  in  BIAS_GROUP_BITS+1  number of output groups (1..2^BIAS_GROUP_BITS)
cfg_bias_words  in  BIAS_GROUP_BITS+1  128-bit bias beats to load
cfg_wt_words_per_group  in  WT_ADDR_WIDTH+1  72-bit weight beats per group
cfg_wt_resident  in  1  1 = load all groups' weights once
ld_data  in  128  load stream data; weights use [71:0]
ld_valid  in  1  load stream valid
ld_ready  out  1  load stream ready
bias_wr_en  out  1  to bias store
bias_wr_data  out  128  ld_data passthrough
bias_wr_addr_rst  out  1  1-cycle pulse
wt_wr_en  out  1  to weight store
wt_wr_data  out  72  ld_data[71:0]
wt_wr_addr_rst  out  1  1-cycle pulse
conv_output_group  out  BIAS_GROUP_BITS  current group
conv_wt_base_addr  out  WT_ADDR_WIDTH  weight base for current group
conv_go  out  1  1-cycle pulse
conv_busy  in  1  engine busy
conv_done  in  1  engine done pulse
grp_active  out  1  high from go until done; host streams pixels while high
layer_busy  out  1  high when not IDLE
layer_done  out  1  1-cycle pulse on completion
layer_err  out  1  1-cycle pulse on rejected start

Behaviour:
- Reset: state IDLE; every output 0; group counter 0.
- Config is latched on accepted layer_start; later cfg changes have no effect until the next layer.
- Start rejection in IDLE:
  - cfg_num_groups == 0, or
  - resident mode with num_groups*wt_words_per_group > WT_DEPTH (21-bit unsigned product).
  - On rejection: layer_err pulses the next cycle and the block stays IDLE.
- States and transitions:
  - IDLE -> BIAS_RST on accepted start.
  - BIAS_RST: bias_wr_addr_rst=1 for one cycle -> BIAS_LOAD.
  - BIAS_LOAD: ld_ready=1. Each beat with ld_valid&ld_ready asserts bias_wr_en the same cycle (combinational), increments the beat count, and carries ld_data to bias_wr_data. After cfg_bias_words beats -> WT_RST. cfg_bias_words=0 skips directly to WT_RST.
  - WT_RST: wt_wr_addr_rst=1 for one cycle -> WT_LOAD.
  - WT_LOAD: same handshake as BIAS_LOAD, driving wt_wr_en and wt_wr_data=ld_data[71:0]. Target beat count is num_groups*per_group in resident mode, per_group otherwise. A zero count skips the load. Then -> GO.
  - GO: wait until conv_busy=0, then pulse conv_go for 1 cycle with conv_output_group=g already stable -> RUN. grp_active rises with conv_go.
  - RUN: on conv_done, grp_active falls.
    - If g == num_groups-1 -> DONE.
    - Otherwise g increments; next state is GO in resident mode, WT_RST in streamed mode.
  - DONE: layer_done=1 for one cycle -> IDLE.
- conv_wt_base_addr: g*per_group in resident mode, 0 in streamed mode. It is registered and updated when g changes, at least one cycle before conv_go.
- ld_ready=0 outside the load states. Beats arriving outside the load states are not consumed.
- conv_output_group and conv_wt_base_addr hold their values between groups and until the next start.
- layer_abort:
  - Highest priority in every state, including the same cycle as conv_done or the last load beat.
  - Next state IDLE; layer_done does not pulse; all pulse outputs and grp_active drop next cycle.
  - A beat accepted in the abort cycle is still written.
- layer_start while not IDLE is ignored and raises no error.
- Synchronous reset mid-layer behaves like an abort and also clears the counters.

Test Plan:
- Streamed mode, num_groups=3, bias_words=2, per_group=5, ld_valid always 1, conv_done 4 cycles after go:
  - exactly 2 bias_wr_en pulses, then 3 rounds of (wt_wr_addr_rst, 5 wt_wr_en, go).
  - conv_output_group 0,1,2; conv_wt_base_addr stays 0.
  - layer_done pulses once.
- Resident mode, num_groups=4, per_group=9:
  - one wt_wr_addr_rst and 36 weight beats.
  - 4 go pulses with base addresses 0, 9, 18, 27; no reload between groups.
- ld_valid toggled randomly, bias_words=3: write count equals accepted beats exactly; no write happens while ld_valid=0.
- conv_busy held high 10 cycles on entering GO: conv_go is delayed until conv_busy falls, then pulses exactly one cycle.
- Error cases:
  - num_groups=0: layer_err pulses, layer_busy stays 0.
  - Resident 200*32 > 4096: layer_err pulses, no writes occur.
- layer_abort asserted in the same cycle as the second group's conv_done: next cycle IDLE, no layer_done, grp_active=0. A following start runs cleanly from group 0.
